// File: rtl/game_pkg.sv
// Shared definitions for the game controller.
// - game_state_e and ST_*: FSM state codes. These codes also appear on the LEDR debug port.
// - bcd_digit_t: one packed BCD digit.
// - SCORE_MAX / LEVEL_MAX: saturation limits for the score and the wave counter.
package game_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PLAYING     = 2'd1,
    LEVEL_CLEAR = 2'd2,
    GAME_OVER   = 2'd3
  } game_state_e;

  // Plain constants so the FSM can be held in a bare logic vector.
  localparam logic [1:0] ST_IDLE        = IDLE;
  localparam logic [1:0] ST_PLAYING     = PLAYING;
  localparam logic [1:0] ST_LEVEL_CLEAR = LEVEL_CLEAR;
  localparam logic [1:0] ST_GAME_OVER   = GAME_OVER;

  localparam logic [15:0] SCORE_MAX = 16'h9999;
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit packed-BCD incrementer. The result saturates at 9999.
//   value_i [15:0]  current BCD value
//   en_i            add one when high; otherwise value_o follows value_i
//   value_o [15:0]  incremented, or unchanged, BCD value
module bcd_inc4
  import game_pkg::*;
(
  input  logic [15:0] value_i,
  input  logic        en_i,
  output logic [15:0] value_o
);

  logic       carry;
  bcd_digit_t dig;

  always_comb begin
    value_o = value_i;
    dig     = '0;
    // At the ceiling no carry is injected, so the value holds.
    carry   = en_i && (value_i != SCORE_MAX);
    for (int i = 0; i < 4; i++) begin
      dig = value_i[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          value_o[4*i +: 4] = 4'd0;
        end else begin
          value_o[4*i +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game flow controller: frame tick generation, start-key edge detection, the
// IDLE/PLAYING/LEVEL_CLEAR/GAME_OVER state machine, BCD score, lives and wave count.
//
// Inputs:
//   Clk              system clock
//   Reset_n          asynchronous active-low reset
//   vsync            raw VGA vsync, asynchronous
//   keycode[7:0]     USB keycode; 8'h00 when no key is held
//   enemy_hit        one-cycle pulse for each enemy destroyed
//   player_hit       one-cycle pulse for each hit on the player
//   enemies_left[5:0] live enemy count
//   invaders_landed  level signal
//
// Outputs (all registered):
//   frame_tick       one-cycle pulse per frame
//   is_playing       high only in PLAYING
//   start            one-cycle pulse that (re)spawns the enemy wave
//   delete_enemies   one-cycle pulse that clears the enemy array
//   score[15:0]      4-digit BCD score
//   lives[1:0]       remaining lives
//   level[3:0]       wave number, binary
//   state[1:0]       FSM state code
module game_controller
  import game_pkg::*;
#(
  parameter logic [7:0]  START_KEY    = 8'h28,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned CLEAR_FRAMES = 120
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vsync,
  input  logic [7:0]  keycode,
  input  logic        enemy_hit,
  input  logic        player_hit,
  input  logic [5:0]  enemies_left,
  input  logic        invaders_landed,
  output logic        frame_tick,
  output logic        is_playing,
  output logic        start,
  output logic        delete_enemies,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic [1:0]  state
);

  localparam int unsigned    CntW    = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLEAR_FRAMES - 1);

  // vsync synchronizer and rising-edge detector.
  logic vs_sync1_q, vs_sync2_q, vs_prev_q;
  logic frame_tick_q;
  logic [7:0] key_prev_q;
  logic start_press;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_sync1_q   <= 1'b1;
      vs_sync2_q   <= 1'b1;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      key_prev_q   <= 8'h00;
    end else begin
      vs_sync1_q   <= vsync;
      vs_sync2_q   <= vs_sync1_q;
      vs_prev_q    <= vs_sync2_q;
      frame_tick_q <= vs_sync2_q & ~vs_prev_q;
      key_prev_q   <= keycode;
    end
  end

  // A held key never retriggers: only the first cycle of START_KEY counts.
  assign start_press = (keycode == START_KEY) && (key_prev_q != START_KEY);

  // Game state.
  logic [1:0]      state_q, state_d;
  logic [15:0]     score_q, score_d, score_inc;
  logic [1:0]      lives_q, lives_d;
  logic [3:0]      level_q, level_d;
  logic            armed_q, armed_d;
  logic [CntW-1:0] clr_cnt_q, clr_cnt_d;
  logic            start_q, start_d;
  logic            delete_q, delete_d;
  logic            is_playing_q, is_playing_d;
  logic            game_over;

  bcd_inc4 u_bcd_inc4 (
    .value_i (score_q),
    .en_i    (enemy_hit),
    .value_o (score_inc)
  );

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    level_d      = level_q;
    armed_d      = armed_q;
    clr_cnt_d    = clr_cnt_q;
    start_d      = 1'b0;
    delete_d     = 1'b0;
    game_over    = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_press) begin
          state_d   = ST_PLAYING;
          start_d   = 1'b1;
          score_d   = 16'h0000;
          lives_d   = 2'(LIVES_INIT);
          level_d   = 4'd1;
          armed_d   = 1'b0;
          clr_cnt_d = '0;
        end
      end
      ST_PLAYING: begin
        // Scoring is independent of any simultaneous state change.
        score_d = score_inc;
        // The enemy count is trusted only after one full frame in this wave.
        if (frame_tick_q) armed_d = 1'b1;
        game_over = invaders_landed || (player_hit && (lives_q == 2'd1));
        if (game_over) begin
          state_d  = ST_GAME_OVER;
          lives_d  = 2'd0;
          delete_d = 1'b1;
        end else begin
          if (player_hit && (lives_q != 2'd0)) lives_d = lives_q - 2'd1;
          if (armed_q && (enemies_left == 6'd0)) begin
            state_d   = ST_LEVEL_CLEAR;
            clr_cnt_d = '0;
          end
        end
      end
      ST_LEVEL_CLEAR: begin
        if (frame_tick_q) begin
          if (clr_cnt_q == CntLast) begin
            state_d   = ST_PLAYING;
            start_d   = 1'b1;
            armed_d   = 1'b0;
            clr_cnt_d = '0;
            level_d   = (level_q == LEVEL_MAX) ? level_q : level_q + 4'd1;
          end else begin
            clr_cnt_d = clr_cnt_q + CntW'(1);
          end
        end
      end
      default: ;
    endcase

    is_playing_d = (state_d == ST_PLAYING);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      score_q      <= 16'h0000;
      lives_q      <= 2'd0;
      level_q      <= 4'd0;
      armed_q      <= 1'b0;
      clr_cnt_q    <= '0;
      start_q      <= 1'b0;
      delete_q     <= 1'b0;
      is_playing_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      armed_q      <= armed_d;
      clr_cnt_q    <= clr_cnt_d;
      start_q      <= start_d;
      delete_q     <= delete_d;
      is_playing_q <= is_playing_d;
    end
  end

  assign frame_tick     = frame_tick_q;
  assign is_playing     = is_playing_q;
  assign start          = start_q;
  assign delete_enemies = delete_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign state          = state_q;

endmodule
